// File: rtl/alu_cmd_issue.sv
// -----------------------------------------------------------------------------
// alu_cmd_issue
//   Issue/retire stage wrapped around a purely combinational 32-bit ALU.
//   Incoming commands {a, b, op} are queued in a small FIFO. The head entry
//   drives the ALU inputs directly. The ALU result and carry-out are captured
//   into a response register, which turns the ALU into a back-pressurable
//   pipeline stage. Total buffering is DEPTH + 1 (FIFO plus response register).
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a/alu_b/alu_op     head entry to the ALU (0 when the FIFO is empty)
//   alu_result/alu_cout    combinational ALU answer for the head entry
//   rsp_valid/rsp_ready    response handshake; rsp_result, rsp_cout, rsp_zero
//   fifo_count             occupied FIFO entries
//   ops_done               retired (captured) operations, wraps to 0
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid & ready are both 1. The producer holds its payload stable while
// valid & !ready. cmd_ready depends only on registered state, so it never
// depends on cmd_valid or on rsp_ready in the same cycle.
// -----------------------------------------------------------------------------
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [2:0]               cmd_op,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_op,
    input  logic [31:0]              alu_result,
    input  logic                     alu_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_cout,
    output logic                     rsp_zero,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] b;
        logic [31:0] a;
    } cmd_t;

    // FIFO storage: not reset, the pointers and count define what is valid.
    cmd_t            mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic            not_empty;
    logic            full;
    logic            push;
    logic            pop;
    cmd_t            head;
    cmd_t            cmd_in;

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        // A full FIFO refuses even when a pop happens this cycle, keeping
        // cmd_ready free of any path from rsp_ready.
        push      = cmd_valid & ~full;
        // The response register can take a new result when it is empty or
        // being drained this cycle.
        pop       = not_empty & (~rsp_valid_q | rsp_ready);
        head      = mem_q[rd_ptr_q];
        cmd_in    = '{op: cmd_op, b: cmd_b, a: cmd_a};
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_zero_d   = rsp_zero_q;
        ops_done_d   = ops_done_q;

        // DEPTH is a power of two, so the pointers wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_cout_d   = alu_cout;
            rsp_zero_d   = (alu_result == 32'd0);
            ops_done_d   = ops_done_q + CNT_W'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_zero_q   <= rsp_zero_d;
            ops_done_q   <= ops_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // The ALU sees all zeros while the FIFO is empty, so stale storage
    // never toggles its inputs.
    always_comb begin
        alu_a  = not_empty ? head.a  : 32'd0;
        alu_b  = not_empty ? head.b  : 32'd0;
        alu_op = not_empty ? head.op : 3'd0;
    end

    assign cmd_ready  = ~full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_zero   = rsp_zero_q;
    assign fifo_count = count_q;
    assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issue
//   Directed bench for alu_cmd_issue. A behavioural ALU answers the DUT's
//   alu_* outputs; expected responses are queued when a command is accepted
//   and compared when a response transfers.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clk;
    logic                   rst_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [31:0]            cmd_a;
    logic [31:0]            cmd_b;
    logic [2:0]             cmd_op;
    logic [31:0]            alu_a;
    logic [31:0]            alu_b;
    logic [2:0]             alu_op;
    logic [31:0]            alu_result;
    logic                   alu_cout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_result;
    logic                   rsp_cout;
    logic                   rsp_zero;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0]       ops_done;

    alu_cmd_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
        .fifo_count (fifo_count),
        .ops_done   (ops_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {cout, result}. Sub carry is "no borrow".
    function automatic logic [32:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0]  op);
        logic [32:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a ^ b};
            3'b101:  r = {1'b0, 31'd0, ($signed(a) < $signed(b))};
            default: r = 33'd0;
        endcase
        return r;
    endfunction

    logic [32:0] alu_ans;
    always_comb begin
        alu_ans    = alu_model(alu_a, alu_b, alu_op);
        alu_result = alu_ans[31:0];
        alu_cout   = alu_ans[32];
    end

    // scoreboard
    logic [32:0] exp_q[$];
    int n_chk     = 0;
    int n_pass    = 0;
    int n_retired = 0;
    int n_acc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake bookkeeping for the cycle about to end, then advance one clock.
    task automatic tick();
        logic        acc;
        logic        xfer;
        logic [32:0] e;
        acc  = cmd_valid && cmd_ready;
        xfer = rsp_valid && rsp_ready;
        if (xfer) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
                chk("rsp_cout",   64'(rsp_cout),   64'(e[32]));
                chk("rsp_zero",   64'(rsp_zero),   64'(e[31:0] == 32'd0));
                n_retired++;
            end
        end
        if (acc) begin
            exp_q.push_back(alu_model(cmd_a, cmd_b, cmd_op));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            tick();
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    int          drain_cycles;
    logic [31:0] held;
    logic [2:0]  op_list [8];

    initial begin
        op_list = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b100, 3'b110, 3'b111};
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd1);
        chk("rst_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_ops_done",   64'(ops_done),   64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_alu_op",     64'(alu_op),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: add with latency check
        rsp_ready = 1'b1;
        drive(32'd5, 32'd3, 3'b000);
        tick();
        cmd_valid = 1'b0;
        chk("t1_no_bypass",  64'(rsp_valid),  64'd0);
        chk("t1_count",      64'(fifo_count), 64'd1);
        chk("t1_alu_a",      64'(alu_a),      64'd5);
        tick();
        chk("t1_rsp_valid",  64'(rsp_valid),  64'd1);
        chk("t1_result",     64'(rsp_result), 64'd8);
        chk("t1_ops_done",   64'(ops_done),   64'd1);
        drain();

        // 2: sub to zero; 3: signed slt
        drive(32'd7, 32'd7, 3'b001);
        tick();
        drive(32'hFFFF_FFFF, 32'd1, 3'b101);
        tick();
        cmd_valid = 1'b0;
        drain();
        chk("t3_last_result", 64'(rsp_result), 64'd1);

        // 4: back-pressure, capacity DEPTH+1
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom, op_list[$urandom_range(0, 7)]);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t4_accepted",  64'(n_acc),      64'd5);
        chk("t4_count",     64'(fifo_count), 64'd4);
        chk("t4_cmd_ready", 64'(cmd_ready),  64'd0);
        held = exp_q[0][31:0];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid",  64'(rsp_valid),  64'd1);
            chk("t4_hold_result", 64'(rsp_result), 64'(held));
        end
        rsp_ready = 1'b1;
        drain_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid) break;
            tick();
            drain_cycles++;
        end
        chk("t4_drain_cycles", 64'(drain_cycles), 64'd5);
        drain();

        // 5: continuous stream of 8, pointers wrap
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, op_list[i]);
            tick();
        end
        cmd_valid = 1'b0;
        drain();
        chk("t5_ops_done", 64'(ops_done), 64'(n_retired[CNT_W-1:0]));
        chk("t5_ops_total", 64'(n_retired), 64'd16);

        // 6: async reset with 3 queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 3'b011);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t6_pre_count",  64'(fifo_count), 64'd3);
        chk("t6_pre_alu_op", 64'(alu_op),     64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid",  64'(rsp_valid),  64'd0);
        chk("t6_count",      64'(fifo_count), 64'd0);
        chk("t6_alu_op",     64'(alu_op),     64'd0);
        chk("t6_cmd_ready",  64'(cmd_ready),  64'd1);
        chk("t6_ops_done",   64'(ops_done),   64'd0);
        exp_q.delete();
        n_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive(32'h8000_0000, 32'h8000_0000, 3'b000);
        tick();
        cmd_valid = 1'b0;
        drain();
        chk("t6_post_ops_done", 64'(ops_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
